// File: rtl/video_mux_cfg_master_if.sv
// AXI4-Lite bus bundle between the video mux configuration master and its
// register slave. Signal names keep the M_AXI_* form of the master ports.
//
// Handshake rule for every channel (AW, W, B, AR, R): a transfer happens on
// the rising clock edge where VALID and READY are both 1. A source that has
// raised VALID keeps it high, with its payload unchanged, until that edge.
// READY may rise before, with, or after VALID.
interface video_mux_cfg_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   M_AXI_AWADDR;
  logic                M_AXI_AWVALID;
  logic                M_AXI_AWREADY;
  logic [DATA_W-1:0]   M_AXI_WDATA;
  logic [DATA_W/8-1:0] M_AXI_WSTRB;
  logic                M_AXI_WVALID;
  logic                M_AXI_WREADY;
  logic [1:0]          M_AXI_BRESP;
  logic                M_AXI_BVALID;
  logic                M_AXI_BREADY;
  logic [ADDR_W-1:0]   M_AXI_ARADDR;
  logic                M_AXI_ARVALID;
  logic                M_AXI_ARREADY;
  logic [DATA_W-1:0]   M_AXI_RDATA;
  logic [1:0]          M_AXI_RRESP;
  logic                M_AXI_RVALID;
  logic                M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
    input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
    output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
  );
endinterface

// File: rtl/video_mux_cfg_master.sv
// Video mux configuration master: on a rising edge of INIT_AXI_TXN it writes
// C_SEED+i to register i (address C_BASE_ADDR+4*i) for i = 0..C_NUM_REGS-1
// over AXI4-Lite, one transfer at a time, and raises TXN_DONE at the end.
// ERROR is sticky for the sequence and reports any non-OKAY response.
//
// Build option: define VIDEO_MUX_CFG_READBACK_EN to add a read-back pass
// that reads every register again and flags ERROR on a data mismatch.
// Without it the read channel is held idle (ARVALID/RREADY/ARADDR = 0).
module video_mux_cfg_master #(
  parameter int          C_M_AXI_ADDR_WIDTH = 32,
  parameter int          C_M_AXI_DATA_WIDTH = 32,
  parameter int          C_NUM_REGS         = 4,
  parameter logic [31:0] C_BASE_ADDR        = 32'h0000_0000,
  parameter logic [31:0] C_SEED             = 32'h0000_0001
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic                   INIT_AXI_TXN,
  output logic                   TXN_DONE,
  output logic                   ERROR,
  output logic [2:0]             dbg_state_o,
  video_mux_cfg_master_if.master m_axi
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam logic [3:0] LAST_IDX = 4'(C_NUM_REGS - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_RESP = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  state_t        state_q;
  logic [3:0]    idx_q;
  logic          init_q;
  logic          awvalid_q;
  logic          wvalid_q;
  logic          bready_q;
  logic [AW-1:0] awaddr_q;
  logic [DW-1:0] wdata_q;
  logic          done_q;
  logic          error_q;

  logic          start;
  logic          aw_done;
  logic          w_done;
  logic [3:0]    idx_next;

  function automatic logic [AW-1:0] reg_addr(input logic [3:0] idx);
    return AW'(C_BASE_ADDR) + AW'({idx, 2'b00});
  endfunction

  function automatic logic [DW-1:0] reg_data(input logic [3:0] idx);
    return DW'(C_SEED + 32'(idx));
  endfunction

  // Start only on a fresh 0->1 transition of the request line.
  assign start    = INIT_AXI_TXN & ~init_q;
  // A write channel counts as done once its VALID has dropped or READY is seen now.
  assign aw_done  = ~awvalid_q | m_axi.M_AXI_AWREADY;
  assign w_done   = ~wvalid_q  | m_axi.M_AXI_WREADY;
  assign idx_next = idx_q + 4'd1;

`ifdef VIDEO_MUX_CFG_READBACK_EN
  logic          arvalid_q;
  logic          rready_q;
  logic [AW-1:0] araddr_q;
`endif

  // Sequencer: walks writes, optional read-back, and holds the result in DONE.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      init_q    <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
`ifdef VIDEO_MUX_CFG_READBACK_EN
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      araddr_q  <= '0;
`endif
    end else begin
      init_q <= INIT_AXI_TXN;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q   <= ST_WR_REQ;
            idx_q     <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            awaddr_q  <= reg_addr(4'd0);
            wdata_q   <= reg_data(4'd0);
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
          end
        end
        ST_WR_REQ: begin
          // AW and W retire independently; move on when both have.
          if (m_axi.M_AXI_AWREADY) awvalid_q <= 1'b0;
          if (m_axi.M_AXI_WREADY)  wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            state_q  <= ST_WR_RESP;
            bready_q <= 1'b1;
          end
        end
        ST_WR_RESP: begin
          if (m_axi.M_AXI_BVALID) begin
            bready_q <= 1'b0;
            if (m_axi.M_AXI_BRESP != 2'b00) error_q <= 1'b1;
            if (idx_q != LAST_IDX) begin
              idx_q     <= idx_next;
              awaddr_q  <= reg_addr(idx_next);
              wdata_q   <= reg_data(idx_next);
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= ST_WR_REQ;
            end else begin
              idx_q <= '0;
`ifdef VIDEO_MUX_CFG_READBACK_EN
              araddr_q  <= reg_addr(4'd0);
              arvalid_q <= 1'b1;
              state_q   <= ST_RD_REQ;
`else
              done_q  <= 1'b1;
              state_q <= ST_DONE;
`endif
            end
          end
        end
`ifdef VIDEO_MUX_CFG_READBACK_EN
        ST_RD_REQ: begin
          if (m_axi.M_AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_RD_RESP;
          end
        end
        ST_RD_RESP: begin
          if (m_axi.M_AXI_RVALID) begin
            rready_q <= 1'b0;
            if ((m_axi.M_AXI_RRESP != 2'b00) || (m_axi.M_AXI_RDATA != reg_data(idx_q)))
              error_q <= 1'b1;
            if (idx_q != LAST_IDX) begin
              idx_q     <= idx_next;
              araddr_q  <= reg_addr(idx_next);
              arvalid_q <= 1'b1;
              state_q   <= ST_RD_REQ;
            end else begin
              idx_q   <= '0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign m_axi.M_AXI_AWADDR  = awaddr_q;
  assign m_axi.M_AXI_AWVALID = awvalid_q;
  assign m_axi.M_AXI_WDATA   = wdata_q;
  assign m_axi.M_AXI_WSTRB   = '1;
  assign m_axi.M_AXI_WVALID  = wvalid_q;
  assign m_axi.M_AXI_BREADY  = bready_q;
`ifdef VIDEO_MUX_CFG_READBACK_EN
  assign m_axi.M_AXI_ARADDR  = araddr_q;
  assign m_axi.M_AXI_ARVALID = arvalid_q;
  assign m_axi.M_AXI_RREADY  = rready_q;
`else
  assign m_axi.M_AXI_ARADDR  = '0;
  assign m_axi.M_AXI_ARVALID = 1'b0;
  assign m_axi.M_AXI_RREADY  = 1'b0;

  // Read-channel inputs are deliberately ignored when read-back is absent.
  logic unused_rd_inputs;
  assign unused_rd_inputs = ^{m_axi.M_AXI_ARREADY, m_axi.M_AXI_RDATA,
                              m_axi.M_AXI_RRESP, m_axi.M_AXI_RVALID};
`endif

  assign TXN_DONE    = done_q;
  assign ERROR       = error_q;
  assign dbg_state_o = state_q;

endmodule
